// File: rtl/gowin_tl_rx_buffer_if.sv
// Stream bundle for gowin_tl_rx_buffer: the TL RX beat port from the Gowin PCIe
// core plus the ready/valid stream towards the RIFFA RX engines.
interface gowin_tl_rx_buffer_if #(
  parameter int C_PCI_DATA_WIDTH = 256
);
  localparam int C_NUM_DW = C_PCI_DATA_WIDTH / 32;
  localparam int C_OFF_W  = (C_NUM_DW > 2) ? $clog2(C_NUM_DW) : 1;

  logic                        TL_RX_SOP;
  logic                        TL_RX_EOP;
  logic [C_PCI_DATA_WIDTH-1:0] TL_RX_DATA;
  logic [C_NUM_DW-1:0]         TL_RX_VALID;
  logic [5:0]                  TL_RX_BARDEC;
  logic [C_NUM_DW-1:0]         TL_RX_ERR;
  logic                        TL_RX_WAIT;

  logic [C_PCI_DATA_WIDTH-1:0] RX_DATA;
  logic                        RX_DATA_VALID;
  logic                        RX_DATA_READY;
  logic                        RX_START_FLAG;
  logic                        RX_END_FLAG;
  logic [C_OFF_W-1:0]          RX_END_OFFSET;
  logic [5:0]                  RX_BAR_DECODE;
  logic                        RX_ERR;

  // slave: the buffer itself; master: the core/engine environment around it
  modport slave (
    input  TL_RX_SOP, TL_RX_EOP, TL_RX_DATA, TL_RX_VALID, TL_RX_BARDEC, TL_RX_ERR,
    input  RX_DATA_READY,
    output TL_RX_WAIT,
    output RX_DATA, RX_DATA_VALID, RX_START_FLAG, RX_END_FLAG, RX_END_OFFSET,
    output RX_BAR_DECODE, RX_ERR
  );

  modport master (
    output TL_RX_SOP, TL_RX_EOP, TL_RX_DATA, TL_RX_VALID, TL_RX_BARDEC, TL_RX_ERR,
    output RX_DATA_READY,
    input  TL_RX_WAIT,
    input  RX_DATA, RX_DATA_VALID, RX_START_FLAG, RX_END_FLAG, RX_END_OFFSET,
    input  RX_BAR_DECODE, RX_ERR
  );
endinterface

// File: rtl/gowin_tl_rx_buffer.sv
// Gowin TL RX beat buffer: FIFO with early TL_RX_WAIT, FWFT registered output stream.
// Define GOWIN_RX_ERR_DROP_EN for store-and-forward with errored/aborted TLP discard.
module gowin_tl_rx_buffer #(
  parameter int C_PCI_DATA_WIDTH = 256,
  parameter int C_FIFO_DEPTH     = 64,
  parameter int C_WAIT_LATENCY   = 3
) (
  input  logic                CLK,
  input  logic                RST_IN,
  gowin_tl_rx_buffer_if.slave bus,
  output logic [15:0]         RX_PKT_COUNT,
  output logic [15:0]         RX_DROP_COUNT,
  output logic                RX_OVERFLOW
);
  localparam int C_NUM_DW = C_PCI_DATA_WIDTH / 32;
  localparam int OFF_W    = (C_NUM_DW > 2) ? $clog2(C_NUM_DW) : 1;
  localparam int AW       = $clog2(C_FIFO_DEPTH);
  localparam int PW       = AW + 1;

  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;

  typedef struct packed {
    logic                        err;
    logic [5:0]                  bar;
    logic [OFF_W-1:0]            off;
    logic                        eop;
    logic                        sop;
    logic [C_PCI_DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t           mem [C_FIFO_DEPTH];
  entry_t           out_reg;
  entry_t           wr_entry;
  state_t           state_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    commit_ptr;
  logic [PW-1:0]    occupancy;
  logic             out_valid_reg;
  logic             wait_reg;
  logic             overflow_reg;
  logic [15:0]      pkt_count_reg;
  logic [15:0]      drop_count_reg;
  logic [5:0]       bar_reg;
  logic [OFF_W-1:0] end_off;
  logic             beat;
  logic             err_any;
  logic             pop;
  logic             load;
  logic             full;
  logic             wr_en;

`ifdef GOWIN_RX_ERR_DROP_EN
  logic [PW-1:0]    commit_ptr_reg;
  assign commit_ptr = commit_ptr_reg;
`else
  assign commit_ptr = wr_ptr_reg;
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  always_comb begin
    end_off = '0;
    for (int i = 0; i < C_NUM_DW; i++) begin
      if (bus.TL_RX_VALID[i]) end_off = OFF_W'(i);
    end
  end

  assign beat    = |bus.TL_RX_VALID;
  assign err_any = |bus.TL_RX_ERR;
  assign pop     = out_valid_reg & bus.RX_DATA_READY;
  // The output register counts as an occupied slot, speculative entries too
  assign occupancy = (wr_ptr_reg - rd_ptr_reg) + PW'(out_valid_reg);
  assign full      = (occupancy == PW'(C_FIFO_DEPTH)) & ~pop;
  assign load      = (commit_ptr != rd_ptr_reg) & (~out_valid_reg | bus.RX_DATA_READY);

  always_comb begin
    wr_en = 1'b0;
    if (beat && !RST_IN && !full) begin
      case (state_reg)
        IDLE:    wr_en = bus.TL_RX_SOP;
        IN_PKT:  wr_en = 1'b1;
        default: wr_en = 1'b0;
      endcase
`ifdef GOWIN_RX_ERR_DROP_EN
      if (err_any || (state_reg == IN_PKT && bus.TL_RX_SOP)) wr_en = 1'b0;
`endif
    end
  end

  always_comb begin
    wr_entry.data = bus.TL_RX_DATA;
    wr_entry.sop  = bus.TL_RX_SOP;
    wr_entry.eop  = bus.TL_RX_EOP;
    wr_entry.off  = end_off;
    wr_entry.bar  = bus.TL_RX_SOP ? bus.TL_RX_BARDEC : bar_reg;
`ifdef GOWIN_RX_ERR_DROP_EN
    wr_entry.err  = 1'b0;
`else
    wr_entry.err  = err_any | (state_reg == IN_PKT && bus.TL_RX_SOP);
`endif
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge CLK) begin
    if (RST_IN) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      wait_reg       <= 1'b1;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
      bar_reg        <= '0;
`ifdef GOWIN_RX_ERR_DROP_EN
      commit_ptr_reg <= '0;
`endif
    end else begin
      // Looks at the current occupancy, so it trails the change by one cycle
      wait_reg <= (C_FIFO_DEPTH - int'(occupancy)) <= (C_WAIT_LATENCY + 1);
      if (beat && bus.TL_RX_SOP) bar_reg <= bus.TL_RX_BARDEC;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
`ifdef GOWIN_RX_ERR_DROP_EN
      if (wr_en && bus.TL_RX_EOP) commit_ptr_reg <= wr_ptr_reg + 1'b1;
`endif
      if (beat) begin
        case (state_reg)
          IDLE: begin
            if (!bus.TL_RX_SOP) begin
              drop_count_reg <= sat_inc(drop_count_reg);
            end else if (full) begin
              overflow_reg   <= 1'b1;
              drop_count_reg <= sat_inc(drop_count_reg);
              if (!bus.TL_RX_EOP) state_reg <= DROP;
`ifdef GOWIN_RX_ERR_DROP_EN
            end else if (err_any) begin
              drop_count_reg <= sat_inc(drop_count_reg);
              if (!bus.TL_RX_EOP) state_reg <= DROP;
`endif
            end else if (!bus.TL_RX_EOP) begin
              state_reg <= IN_PKT;
            end
          end
          IN_PKT: begin
            if (full) begin
              overflow_reg   <= 1'b1;
              drop_count_reg <= sat_inc(drop_count_reg);
`ifdef GOWIN_RX_ERR_DROP_EN
              wr_ptr_reg     <= commit_ptr_reg;
`endif
              state_reg      <= bus.TL_RX_EOP ? IDLE : DROP;
`ifdef GOWIN_RX_ERR_DROP_EN
            end else if (bus.TL_RX_SOP || err_any) begin
              drop_count_reg <= sat_inc(drop_count_reg);
              wr_ptr_reg     <= commit_ptr_reg;
              state_reg      <= bus.TL_RX_EOP ? IDLE : DROP;
`else
            end else if (bus.TL_RX_SOP) begin
              // Abort: the new TLP is already written with its error flag set
              drop_count_reg <= sat_inc(drop_count_reg);
              if (bus.TL_RX_EOP) state_reg <= IDLE;
`endif
            end else if (bus.TL_RX_EOP) begin
              state_reg <= IDLE;
            end
          end
          default: begin
            if (bus.TL_RX_EOP) state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_IN) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      rd_ptr_reg    <= '0;
      pkt_count_reg <= '0;
    end else begin
      if (load) begin
        out_reg       <= mem[rd_ptr_reg[AW-1:0]];
        out_valid_reg <= 1'b1;
        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
      end else if (pop) begin
        out_valid_reg <= 1'b0;
      end
      if (pop && out_reg.eop) pkt_count_reg <= pkt_count_reg + 16'd1;
    end
  end

  assign bus.TL_RX_WAIT    = wait_reg;
  assign bus.RX_DATA       = out_reg.data;
  assign bus.RX_DATA_VALID = out_valid_reg;
  assign bus.RX_START_FLAG = out_reg.sop;
  assign bus.RX_END_FLAG   = out_reg.eop;
  assign bus.RX_END_OFFSET = out_reg.off;
  assign bus.RX_BAR_DECODE = out_reg.bar;
  assign bus.RX_ERR        = out_reg.err;
  assign RX_PKT_COUNT      = pkt_count_reg;
  assign RX_DROP_COUNT     = drop_count_reg;
  assign RX_OVERFLOW       = overflow_reg;
endmodule

// File: tb/tb_gowin_tl_rx_buffer.sv
// Bench for gowin_tl_rx_buffer: a 256-bit instance driven from a vector table and a
// 64-bit depth-8 instance exercising wait, overflow, abort, error and reset sequences.
module tb_gowin_tl_rx_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gowin_tl_rx_buffer_if #(.C_PCI_DATA_WIDTH(256)) bw();
  gowin_tl_rx_buffer_if #(.C_PCI_DATA_WIDTH(64))  bn();

  logic [15:0] w_pkt, w_drop, n_pkt, n_drop;
  logic        w_ovf, n_ovf;

  gowin_tl_rx_buffer #(.C_PCI_DATA_WIDTH(256), .C_FIFO_DEPTH(64), .C_WAIT_LATENCY(3)) u_wide (
    .CLK(clk), .RST_IN(rst), .bus(bw),
    .RX_PKT_COUNT(w_pkt), .RX_DROP_COUNT(w_drop), .RX_OVERFLOW(w_ovf)
  );

  gowin_tl_rx_buffer #(.C_PCI_DATA_WIDTH(64), .C_FIFO_DEPTH(8), .C_WAIT_LATENCY(3)) u_narrow (
    .CLK(clk), .RST_IN(rst), .bus(bn),
    .RX_PKT_COUNT(n_pkt), .RX_DROP_COUNT(n_drop), .RX_OVERFLOW(n_ovf)
  );

  typedef struct {
    logic [7:0] valid;
    logic [5:0] bar;
    logic [7:0] err;
    logic       deliver;
    logic [2:0] off;
    logic       eflag;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic        off;
    logic        err;
    logic [5:0]  bar;
  } beat_t;

  int    n_chk = 0;
  int    n_err = 0;
  beat_t got[$];
  vec_t  vecs[5];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dn(input int tag, input int k);
    return {32'(tag), 32'(k)};
  endfunction

  task automatic push_n(input logic sop, input logic eop, input logic [1:0] vld,
                        input logic [63:0] d, input logic [5:0] bar, input logic [1:0] err);
    bn.TL_RX_SOP    = sop;
    bn.TL_RX_EOP    = eop;
    bn.TL_RX_VALID  = vld;
    bn.TL_RX_DATA   = d;
    bn.TL_RX_BARDEC = bar;
    bn.TL_RX_ERR    = err;
    @(negedge clk);
  endtask

  task automatic idle_n();
    bn.TL_RX_SOP   = 1'b0;
    bn.TL_RX_EOP   = 1'b0;
    bn.TL_RX_VALID = '0;
    bn.TL_RX_ERR   = '0;
  endtask

  task automatic collect(input int cycles);
    beat_t b;
    got.delete();
    bn.RX_DATA_READY = 1'b1;
    repeat (cycles) begin
      if (bn.RX_DATA_VALID) begin
        b.data = bn.RX_DATA;
        b.sop  = bn.RX_START_FLAG;
        b.eop  = bn.RX_END_FLAG;
        b.off  = bn.RX_END_OFFSET;
        b.err  = bn.RX_ERR;
        b.bar  = bn.RX_BAR_DECODE;
        got.push_back(b);
        $display("  rx beat data=%h sop=%b eop=%b off=%0d err=%b bar=%h",
                 b.data, b.sop, b.eop, b.off, b.err, b.bar);
      end
      @(negedge clk);
    end
    bn.RX_DATA_READY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [255:0] wdata;
    int exp_wpkt = 0;
    int exp_wdrop = 0;
    int exp_npkt = 0;
    int exp_ndrop = 0;
    int n_exp;

    vecs[0] = '{valid: 8'h07, bar: 6'h01, err: 8'h00, deliver: 1'b1, off: 3'd2, eflag: 1'b0};
    vecs[1] = '{valid: 8'h01, bar: 6'h3F, err: 8'h00, deliver: 1'b1, off: 3'd0, eflag: 1'b0};
    vecs[2] = '{valid: 8'hFF, bar: 6'h20, err: 8'h00, deliver: 1'b1, off: 3'd7, eflag: 1'b0};
`ifdef GOWIN_RX_ERR_DROP_EN
    vecs[3] = '{valid: 8'h0F, bar: 6'h04, err: 8'h02, deliver: 1'b0, off: 3'd3, eflag: 1'b0};
`else
    vecs[3] = '{valid: 8'h0F, bar: 6'h04, err: 8'h02, deliver: 1'b1, off: 3'd3, eflag: 1'b1};
`endif
    vecs[4] = '{valid: 8'h1F, bar: 6'h10, err: 8'h00, deliver: 1'b1, off: 3'd4, eflag: 1'b0};

    rst = 1'b1;
    bw.TL_RX_SOP = 0; bw.TL_RX_EOP = 0; bw.TL_RX_VALID = '0; bw.TL_RX_ERR = '0;
    bw.TL_RX_DATA = '0; bw.TL_RX_BARDEC = '0; bw.RX_DATA_READY = 0;
    bn.TL_RX_DATA = '0; bn.TL_RX_BARDEC = '0; bn.RX_DATA_READY = 0;
    idle_n();
    repeat (3) @(negedge clk);
    chk("rst_wait_w", bw.TL_RX_WAIT, 1'b1);
    chk("rst_valid_w", bw.RX_DATA_VALID, 1'b0);
    chk("rst_counts_w", {w_pkt, w_drop, w_ovf}, '0);
    chk("rst_wait_n", bn.TL_RX_WAIT, 1'b1);
    chk("rst_valid_n", bn.RX_DATA_VALID, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("wait_after_rst", bn.TL_RX_WAIT, 1'b0);

    // Single-beat TLPs through the 256-bit instance
    for (int i = 0; i < 5; i++) begin
      wdata = {8{32'hA000_0000 | 32'(i)}};
      bw.TL_RX_SOP = 1; bw.TL_RX_EOP = 1; bw.TL_RX_VALID = vecs[i].valid;
      bw.TL_RX_BARDEC = vecs[i].bar; bw.TL_RX_ERR = vecs[i].err; bw.TL_RX_DATA = wdata;
      @(negedge clk);
      bw.TL_RX_SOP = 0; bw.TL_RX_EOP = 0; bw.TL_RX_VALID = '0; bw.TL_RX_ERR = '0;
      chk($sformatf("v%0d_latency", i), bw.RX_DATA_VALID, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), bw.RX_DATA_VALID, vecs[i].deliver);
      if (vecs[i].deliver) begin
        chk($sformatf("v%0d_flags", i), {bw.RX_START_FLAG, bw.RX_END_FLAG}, 2'b11);
        chk($sformatf("v%0d_off", i), bw.RX_END_OFFSET, vecs[i].off);
        chk($sformatf("v%0d_bar", i), bw.RX_BAR_DECODE, vecs[i].bar);
        chk($sformatf("v%0d_err", i), bw.RX_ERR, vecs[i].eflag);
        chk($sformatf("v%0d_data", i), bw.RX_DATA, wdata);
        exp_wpkt++;
      end else begin
        exp_wdrop++;
      end
      bw.RX_DATA_READY = 1;
      @(negedge clk);
      bw.RX_DATA_READY = 0;
      chk($sformatf("v%0d_popped", i), bw.RX_DATA_VALID, 1'b0);
      chk($sformatf("v%0d_pkt", i), w_pkt, 16'(exp_wpkt));
      chk($sformatf("v%0d_drop", i), w_drop, 16'(exp_wdrop));
      $display("vec %0d: valid=%h bar=%h err=%h deliver=%0d pkt=%0d drop=%0d",
               i, vecs[i].valid, vecs[i].bar, vecs[i].err, vecs[i].deliver, w_pkt, w_drop);
    end

    // 5-beat TLP with READY low: wait rises after occupancy reaches 4
    for (int k = 0; k < 5; k++) begin
      push_n(k == 0, k == 4, 2'b11, dn(32'hB000, k), 6'h02, 2'b00);
      chk($sformatf("a_wait%0d", k), bn.TL_RX_WAIT, k == 4);
    end
    idle_n();
    collect(12);
    exp_npkt++;
    chk("a_count", got.size(), 5);
    for (int k = 0; k < got.size(); k++) begin
      chk($sformatf("a_data%0d", k), got[k].data, dn(32'hB000, k));
      chk($sformatf("a_flags%0d", k), {got[k].sop, got[k].eop}, {k == 0, k == 4});
    end
    if (got.size() == 5) chk("a_off_last", got[4].off, 1'b1);
    chk("a_pkt", n_pkt, 16'(exp_npkt));
    chk("a_wait_drained", bn.TL_RX_WAIT, 1'b0);
    $display("seq wait: beats=%0d pkt=%0d", got.size(), n_pkt);

    // Ten beats into depth 8 while ignoring wait
    for (int k = 0; k < 10; k++) push_n(k == 0, k == 9, 2'b11, dn(32'hC000, k), 6'h04, 2'b00);
    idle_n();
    exp_ndrop++;
    chk("b_overflow", n_ovf, 1'b1);
    chk("b_drop", n_drop, 16'(exp_ndrop));
    collect(20);
`ifdef GOWIN_RX_ERR_DROP_EN
    n_exp = 0;
`else
    n_exp = 8;
`endif
    chk("b_count", got.size(), n_exp);
    for (int k = 0; k < got.size(); k++) begin
      chk($sformatf("b_data%0d", k), got[k].data, dn(32'hC000, k));
      chk($sformatf("b_flags%0d", k), {got[k].sop, got[k].eop}, {k == 0, 1'b0});
    end
    chk("b_pkt", n_pkt, 16'(exp_npkt));
    push_n(1'b1, 1'b0, 2'b11, dn(32'hD000, 0), 6'h08, 2'b00);
    push_n(1'b0, 1'b1, 2'b01, dn(32'hD000, 1), 6'h00, 2'b00);
    idle_n();
    collect(10);
    exp_npkt++;
    chk("b_next_count", got.size(), 2);
    for (int k = 0; k < got.size(); k++) begin
      chk($sformatf("b_next_data%0d", k), got[k].data, dn(32'hD000, k));
      chk($sformatf("b_next_bar%0d", k), got[k].bar, 6'h08);
      chk($sformatf("b_next_flags%0d", k), {got[k].sop, got[k].eop}, {k == 0, k == 1});
    end
    if (got.size() == 2) chk("b_next_off", got[1].off, 1'b0);
    chk("b_next_pkt", n_pkt, 16'(exp_npkt));
    chk("b_ovf_sticky", n_ovf, 1'b1);
    $display("seq overflow: drop=%0d pkt=%0d ovf=%b", n_drop, n_pkt, n_ovf);

    // SOP arriving inside a TLP aborts it
    push_n(1'b1, 1'b0, 2'b11, dn(32'hE000, 0), 6'h02, 2'b00);
    push_n(1'b0, 1'b0, 2'b11, dn(32'hE000, 1), 6'h00, 2'b00);
    push_n(1'b1, 1'b0, 2'b11, dn(32'hE000, 2), 6'h08, 2'b00);
    push_n(1'b0, 1'b1, 2'b11, dn(32'hE000, 3), 6'h00, 2'b00);
    idle_n();
    exp_ndrop++;
    chk("c_drop", n_drop, 16'(exp_ndrop));
    collect(12);
`ifdef GOWIN_RX_ERR_DROP_EN
    chk("c_count", got.size(), 0);
`else
    exp_npkt++;
    chk("c_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("c_first_bar", got[0].bar, 6'h02);
      chk("c_first_err", got[0].err, 1'b0);
      chk("c_abort_flags", {got[2].sop, got[2].eop, got[2].err}, 3'b101);
      chk("c_abort_bar", got[2].bar, 6'h08);
      chk("c_tail_flags", {got[3].sop, got[3].eop, got[3].err}, 3'b010);
      chk("c_tail_bar", got[3].bar, 6'h08);
      chk("c_tail_data", got[3].data, dn(32'hE000, 3));
    end
`endif
    chk("c_pkt", n_pkt, 16'(exp_npkt));
    $display("seq abort: beats=%0d drop=%0d pkt=%0d", got.size(), n_drop, n_pkt);

    // Error on the third beat, then a clean single-beat TLP
    for (int k = 0; k < 4; k++)
      push_n(k == 0, k == 3, 2'b11, dn(32'hF000, k), 6'h01, (k == 2) ? 2'b01 : 2'b00);
    push_n(1'b1, 1'b1, 2'b01, dn(32'hF100, 0), 6'h20, 2'b00);
    idle_n();
    collect(14);
`ifdef GOWIN_RX_ERR_DROP_EN
    exp_ndrop++;
    exp_npkt++;
    chk("d_count", got.size(), 1);
    if (got.size() == 1) begin
      chk("d_clean_data", got[0].data, dn(32'hF100, 0));
      chk("d_clean_flags", {got[0].sop, got[0].eop, got[0].err}, 3'b110);
    end
`else
    exp_npkt += 2;
    chk("d_count", got.size(), 5);
    for (int k = 0; k < got.size(); k++)
      chk($sformatf("d_err%0d", k), got[k].err, k == 2);
    if (got.size() == 5) chk("d_clean_data", got[4].data, dn(32'hF100, 0));
`endif
    chk("d_drop", n_drop, 16'(exp_ndrop));
    chk("d_pkt", n_pkt, 16'(exp_npkt));
    $display("seq error: beats=%0d drop=%0d pkt=%0d", got.size(), n_drop, n_pkt);

    // Reset mid-TLP with three entries queued
    for (int k = 0; k < 3; k++) push_n(k == 0, 1'b0, 2'b11, dn(32'h9000, k), 6'h02, 2'b00);
    idle_n();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("e_valid", bn.RX_DATA_VALID, 1'b0);
    chk("e_counts", {n_pkt, n_drop, n_ovf}, '0);
    chk("e_wait_rst", bn.TL_RX_WAIT, 1'b1);
    @(negedge clk);
    chk("e_wait_after", bn.TL_RX_WAIT, 1'b0);
    push_n(1'b0, 1'b1, 2'b11, dn(32'h9100, 0), 6'h02, 2'b00);
    idle_n();
    repeat (3) @(negedge clk);
    chk("e_nonsop_valid", bn.RX_DATA_VALID, 1'b0);
    chk("e_nonsop_drop", n_drop, 16'd1);
    $display("seq reset: valid=%b drop=%0d pkt=%0d", bn.RX_DATA_VALID, n_drop, n_pkt);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/gowin_tl_rx_buffer.md
Name: gowin_tl_rx_buffer

Overview:
- Parametrised receive-side buffer between the Gowin PCIe controller transaction-layer RX port and the RIFFA RX engines.
- Accepts sop/eop/per-dword-valid beats of 64, 128 or 256 bits and stores them in an internal FIFO.
- Drives TL_RX_WAIT early enough to absorb the core's post-wait skid.
- Presents a ready/valid stream carrying start/end flags, end-dword offset and BAR decode.
- Successor to the fixed 256-bit, unbuffered hookup; adds width generality, flow control, error accounting and optional errored-packet discard.

Parameters:
- C_PCI_DATA_WIDTH, 256, beat width in bits; legal values 64, 128, 256. Derived: C_NUM_DW = C_PCI_DATA_WIDTH/32.
- C_FIFO_DEPTH, 64, number of entries; power of two, at least 8.
- C_WAIT_LATENCY, 3, beats the core may still deliver after TL_RX_WAIT rises; must be less than C_FIFO_DEPTH-2.

Ports:
- CLK  in  1  controller TL clock.
- RST_IN  in  1  synchronous active-high reset.
- TL_RX_SOP  in  1  start of TLP.
- TL_RX_EOP  in  1  end of TLP.
- TL_RX_DATA  in  C_PCI_DATA_WIDTH  beat data.
- TL_RX_VALID  in  C_NUM_DW  per-dword valid, contiguous from bit 0.
- TL_RX_BARDEC  in  6  BAR hit, sampled on the SOP beat.
- TL_RX_ERR  in  C_NUM_DW  per-dword error.
- TL_RX_WAIT  out  1  backpressure to core.
- RX_DATA  out  C_PCI_DATA_WIDTH  output data.
- RX_DATA_VALID  out  1  output beat valid.
- RX_DATA_READY  in  1  consumer ready.
- RX_START_FLAG  out  1  first beat of a TLP.
- RX_END_FLAG  out  1  last beat of a TLP.
- RX_END_OFFSET  out  clog2(C_NUM_DW) (minimum 1)  index of last valid dword on an end beat.
- RX_BAR_DECODE  out  6  BAR hit of the current TLP.
- RX_ERR  out  1  error flag on the beat (cut-through build only; otherwise 0).
- RX_PKT_COUNT  out  16  TLPs delivered, wraps.
- RX_DROP_COUNT  out  16  beats/TLPs discarded, saturates at 0xFFFF.
- RX_OVERFLOW  out  1  sticky: a beat arrived while the FIFO was full.

Behaviour:
- Reset values: all outputs 0 except TL_RX_WAIT = 1 for the reset cycle. The FIFO is empty and the state is IDLE.
- A beat is accepted when any TL_RX_VALID bit is set; beats with valid == 0 are ignored.
- The entry stores data, sop, eop, end offset (index of the highest set valid bit) and bardec (latched at SOP, replicated on every beat).
- Write-state FSM:
  - IDLE: an SOP beat is written; if EOP is also set, stay IDLE, else go to IN_PKT. A non-SOP beat is discarded and RX_DROP_COUNT increments.
  - IN_PKT: beats are written; EOP returns to IDLE. An SOP beat here is an abort: the previous TLP is aborted (see the optional feature), RX_DROP_COUNT increments, and the new TLP starts.
  - DROP: beats are discarded until EOP, then go to IDLE.
- Free = C_FIFO_DEPTH - occupancy. TL_RX_WAIT is registered and equals (free <= C_WAIT_LATENCY+1); it updates one cycle after the occupancy change.
- Write while full: the beat is dropped, RX_OVERFLOW is set (cleared only by reset), RX_DROP_COUNT increments, and the FSM goes to DROP unless that beat had EOP.
- Read side:
  - First-word-fall-through; RX_DATA_VALID = committed entries > 0.
  - A pop happens on VALID && READY.
  - Outputs are registered; latency from accepted beat to RX_DATA_VALID is 2 cycles (cut-through) when empty.
  - RX_PKT_COUNT increments on the pop of an end beat.
- Simultaneous push and pop keeps occupancy unchanged; a full FIFO with a pop accepts the push in the same cycle.
- Pointers are log2(C_FIFO_DEPTH)+1 bits and wrap naturally.

Optional Feature:
- Macro: GOWIN_RX_ERR_DROP_EN.
- Defined (store-and-forward):
  - Writes advance a speculative pointer; the committed pointer is set to it on EOP.
  - Any TL_RX_ERR bit on a beat, an abort, or an overflow rolls the speculative pointer back to committed and goes to DROP (the current beat is discarded). RX_DROP_COUNT increments once per TLP.
  - RX_ERR is tied to 0. Every delivered TLP is complete and error-free.
  - Requires C_FIFO_DEPTH >= max TLP beats + C_WAIT_LATENCY + 2.
- Undefined (cut-through):
  - Commit occurs on every write.
  - RX_ERR = OR of TL_RX_ERR on that beat.
  - An aborting SOP beat is written with RX_ERR = 1.
  - After an overflow, stream integrity is undefined until reset.

Test Plan:
- Width 256, single-beat TLP: SOP=EOP=1, VALID=0x07, BARDEC=0x01 -> two cycles later one beat with START=END=1, END_OFFSET=2, BAR_DECODE=0x01; RX_PKT_COUNT=1.
- Width 64, 5-beat TLP with READY held 0 and depth 8, latency 3 -> TL_RX_WAIT rises when occupancy reaches 4, and no beats are lost. After READY=1, 5 beats are delivered in order, with END_OFFSET=1 on the last beat.
- Core ignores wait and pushes 10 beats into depth 8 -> RX_OVERFLOW=1, RX_DROP_COUNT=1, rest of TLP discarded, next TLP delivered intact.
- GOWIN_RX_ERR_DROP_EN defined, 4-beat TLP with TL_RX_ERR=0x01 on beat 3 -> nothing delivered, RX_DROP_COUNT=1; the following clean TLP is delivered with RX_PKT_COUNT=1.
- Cut-through build, SOP in IN_PKT -> the new first beat is delivered with START=1 and RX_ERR=1; RX_DROP_COUNT=1.
- RST_IN asserted mid-TLP with 3 entries queued -> next cycle RX_DATA_VALID=0, counters=0, TL_RX_WAIT=1 for one cycle, then 0; a non-SOP beat after reset is discarded.
